// File: rtl/spw_light_status_cond.sv
// ----------------------------------------------------------------------------
// spw_light_status_cond -- SpaceWire link status conditioner: input sync,
// debounced link-up FSM, sticky error flags, saturating link-up counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spw_light_status_cond #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       link_running_a,
  input  logic       err_disc_a,
  input  logic       err_par_a,
  input  logic       err_esc_a,
  input  logic       err_cred_a,
  input  logic       err_clr,
  input  logic       cnt_clr,
  output logic [1:0] ctrl_out,
  output logic [4:0] err_flags,
  output logic [7:0] up_cnt
);

  localparam logic [1:0] ST_DOWN  = 2'd0;
  localparam logic [1:0] ST_QUAL  = 2'd1;
  localparam logic [1:0] ST_UP    = 2'd2;
  localparam logic [7:0] DBC_LAST = 8'(DEBOUNCE_CYC - 1);

  logic [4:0]                  async_in;
  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic                        running_s;
  logic [3:0]                  err_s;
  logic [3:0]                  err_prev_q, err_prev_d;
  logic [3:0]                  err_rise;
  logic [1:0]                  state_q, state_d;
  logic [7:0]                  dbc_q, dbc_d;
  logic [4:0]                  err_flags_q, err_flags_d;
  logic [7:0]                  up_cnt_q, up_cnt_d;
  logic                        link_won;
  logic                        link_lost;

  // Bit 0 is the link level, bits 4:1 line up with err_flags[3:0].
  assign async_in  = {err_cred_a, err_esc_a, err_par_a, err_disc_a, link_running_a};
  assign running_s = sync_q[SYNC_STAGES-1][0];
  assign err_s     = sync_q[SYNC_STAGES-1][4:1];
  assign err_rise  = err_s & ~err_prev_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], async_in};
    err_prev_d = err_s;
  end

  always_comb begin
    state_d   = state_q;
    dbc_d     = dbc_q;
    link_won  = 1'b0;
    link_lost = 1'b0;
    case (state_q)
      ST_DOWN: begin
        dbc_d = 8'd0;
        if (running_s) state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (!running_s) begin
          state_d = ST_DOWN;
          dbc_d   = 8'd0;
        end else if (dbc_q == DBC_LAST) begin
          state_d  = ST_UP;
          link_won = 1'b1;
        end else begin
          dbc_d = dbc_q + 8'd1;
        end
      end
      ST_UP: begin
        if (!running_s) begin
          state_d   = ST_DOWN;
          link_lost = 1'b1;
        end
      end
      default: begin
        state_d = ST_DOWN;
        dbc_d   = 8'd0;
      end
    endcase
  end

  // A bit being set in the same cycle as err_clr survives the clear.
  always_comb begin
    err_flags_d = (err_clr ? 5'd0 : err_flags_q) | {link_lost, err_rise};
    up_cnt_d    = up_cnt_q;
    if (cnt_clr)
      up_cnt_d = 8'd0;
    else if (link_won && (up_cnt_q != 8'hFF))
      up_cnt_d = up_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      err_prev_q  <= '0;
      state_q     <= ST_DOWN;
      dbc_q       <= '0;
      err_flags_q <= '0;
      up_cnt_q    <= '0;
    end else begin
      sync_q      <= sync_d;
      err_prev_q  <= err_prev_d;
      state_q     <= state_d;
      dbc_q       <= dbc_d;
      err_flags_q <= err_flags_d;
      up_cnt_q    <= up_cnt_d;
    end
  end

  assign ctrl_out  = {|err_flags_q, state_q == ST_UP};
  assign err_flags = err_flags_q;
  assign up_cnt    = up_cnt_q;

endmodule

`default_nettype wire
